// File: rtl/hex_scan_ctrl_pkg.sv
// Shared types and constants for the hex display scan controller.
//   state_t   : scan FSM states (IDLE, BLANK, DRIVE)
//   SEG_CODES : active-low a..g codes for nibbles 0..F (bit7 = dp, off)
//   SEG_OFF / SEL_OFF : all segments / all digits dark
package hex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEL_OFF = 8'hFF;

  localparam logic [7:0] SEG_CODES [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/hex_scan_ctrl_if.sv
// Bus between the hex counter / board pins and hex_scan_ctrl.
//   hex_data, data_valid, dp_mask, enable : driven by the master (source side)
//   seg, sel, data_ack, frame_done        : driven by the slave (controller)
//   state                                 : controller FSM state, debug only
// Handshake: data_valid is a one-cycle strobe with no ready; the controller
// always accepts it. data_ack pulses once when an accepted value becomes the
// displayed value; several strobes before that yield a single ack.
interface hex_scan_ctrl_if;
  import hex_pkg::*;

  logic [31:0] hex_data;
  logic        data_valid;
  logic [7:0]  dp_mask;
  logic        enable;
  logic [7:0]  seg;
  logic [7:0]  sel;
  logic        data_ack;
  logic        frame_done;
  state_t      state;

  modport master (
    output hex_data, data_valid, dp_mask, enable,
    input  seg, sel, data_ack, frame_done, state
  );

  modport slave (
    input  hex_data, data_valid, dp_mask, enable,
    output seg, sel, data_ack, frame_done, state
  );

endinterface

// File: rtl/hex_scan_ctrl_seg_decode.sv
// Combinational nibble + decimal point -> active-low 8-bit segment pattern.
//   nibble : hex digit 0..F
//   dp     : 1 = light the decimal point
//   seg    : bit0..6 = a..g, bit7 = dp, all active-low
module hex_seg_decode
  import hex_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] code;

  always_comb begin
    code = SEG_CODES[nibble];
    seg  = {~dp, code[6:0]};
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Scans an 8-digit common-anode seven-segment display from a 32-bit value.
// Each digit slot is DIGIT_CYC cycles: BLANK_CYC dark cycles to stop ghosting,
// then the digit is driven. New data is double-buffered and only replaces the
// displayed value at a frame boundary (end of the last digit's slot, or any
// cycle while idle).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : hex_scan_ctrl_if.slave (data in, seg/sel/ack/frame out)
module hex_scan_ctrl
  import hex_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int BLANK_CYC   = 500,
  parameter int DIGITS      = 8,
  parameter int LZ_SUPPRESS = 1
) (
  input logic             clk,
  input logic             rst_n,
  hex_scan_ctrl_if.slave  bus
);

  localparam int DIGIT_CYC = CLK_FREQ / SCAN_HZ;
  localparam int CNT_W     = $clog2(DIGIT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIGIT_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [2:0]       DIGIT_LAST = 3'(DIGITS - 1);

  if (BLANK_CYC <= 0 || BLANK_CYC >= DIGIT_CYC) begin : g_bad_blank
    $error("hex_scan_ctrl: BLANK_CYC must satisfy 0 < BLANK_CYC < DIGIT_CYC");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("hex_scan_ctrl: DIGITS must be 1..8");
  end

  state_t           state_q, state_d;
  logic [2:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      display_q, pending_q;
  logic             pending_valid_q;
  logic [7:0]       seg_q, sel_q, seg_d, sel_d;
  logic             data_ack_q, frame_done_q;

  logic             last_slot, boundary, lz_blank, dp;
  logic [31:0]      shifted;
  logic [7:0]       dec_seg;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      digit_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; dropping enable wins over everything
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;
    if (!bus.enable) begin
      state_d = IDLE;
      digit_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          digit_d = '0;
          cnt_d   = '0;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = DRIVE;
        end
        DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = BLANK;
            digit_d = (digit_q == DIGIT_LAST) ? 3'd0 : digit_q + 3'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign last_slot = (state_q == DRIVE) && (cnt_q == CNT_LAST) && (digit_q == DIGIT_LAST);
  assign boundary  = last_slot || (state_q == IDLE);

  // Current digit's nibble and decimal point
  assign shifted = display_q >> {digit_q, 2'b00};
  assign dp      = bus.dp_mask[digit_q];

  hex_seg_decode u_decode (
    .nibble (shifted[3:0]),
    .dp     (dp),
    .seg    (dec_seg)
  );

  // A digit above 0 is a leading zero when it and every higher digit are 0
  always_comb begin
    lz_blank = 1'b0;
    if (LZ_SUPPRESS != 0 && digit_q != 3'd0) begin
      lz_blank = 1'b1;
      for (int i = 1; i < DIGITS; i++) begin
        if (i >= int'(digit_q) && display_q[4*i +: 4] != 4'd0) lz_blank = 1'b0;
      end
    end
  end

  // Suppressed digits keep their select so the scan timing stays uniform
  always_comb begin
    seg_d = SEG_OFF;
    sel_d = SEL_OFF;
    if (bus.enable && state_q == DRIVE) begin
      sel_d = ~(8'h01 << digit_q);
      seg_d = lz_blank ? {~dp, 7'h7F} : dec_seg;
    end
  end

  // Output registers and the pending/display double buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q           <= SEG_OFF;
      sel_q           <= SEL_OFF;
      data_ack_q      <= 1'b0;
      frame_done_q    <= 1'b0;
      display_q       <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= last_slot;
      data_ack_q   <= 1'b0;
      if (boundary) begin
        // A strobe landing on the boundary bypasses the pending register
        if (bus.data_valid) begin
          display_q       <= bus.hex_data;
          data_ack_q      <= 1'b1;
          pending_valid_q <= 1'b0;
        end else if (pending_valid_q) begin
          display_q       <= pending_q;
          data_ack_q      <= 1'b1;
          pending_valid_q <= 1'b0;
        end
      end else if (bus.data_valid) begin
        pending_q       <= bus.hex_data;
        pending_valid_q <= 1'b1;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.sel        = sel_q;
  assign bus.data_ack   = data_ack_q;
  assign bus.frame_done = frame_done_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
module tb_hex_scan_ctrl;
  import hex_pkg::*;

  localparam int DC    = 10;
  localparam int BC    = 2;
  localparam int ND    = 8;
  localparam int FRAME = DC * ND;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hex_scan_ctrl_if bus ();

  hex_scan_ctrl #(
    .CLK_FREQ    (1000),
    .SCAN_HZ     (100),
    .BLANK_CYC   (BC),
    .DIGITS      (ND),
    .LZ_SUPPRESS (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [17:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: frame position counter instead of an FSM
  bit          m_run;
  int          m_t;
  logic [31:0] m_disp, m_pend;
  bit          m_pv;
  logic [7:0]  codes [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // observations
  int          fd_seen, ack_seen;
  bit          last_fd, last_ack;
  logic [7:0]  obs_seg [ND];
  logic [7:0]  cur_dp;

  task automatic model_reset();
    m_run = 0; m_t = 0; m_disp = '0; m_pend = '0; m_pv = 0;
  endtask

  function automatic logic [7:0] model_seg(input int d, input logic [7:0] dp);
    logic [7:0] s;
    bit upper_zero;
    upper_zero = 1;
    for (int i = d; i < ND; i++) if (m_disp[4*i +: 4] != 4'd0) upper_zero = 0;
    if (d > 0 && upper_zero) s = 8'h7F;
    else s = codes[m_disp[4*d +: 4]] & 8'h7F;
    s[7] = ~dp[d];
    return s;
  endfunction

  // driver: one clock cycle of stimulus, expected output pushed, DUT output popped
  task automatic step(input bit en, input bit dv, input logic [31:0] hd, input logic [7:0] dp);
    logic [7:0]  e_seg, e_sel;
    bit          e_ack, e_fd, bnd;
    int          d, ph;
    logic [17:0] got, exp;
    @(negedge clk);
    bus.enable = en; bus.data_valid = dv; bus.hex_data = hd; bus.dp_mask = dp;
    e_seg = 8'hFF; e_sel = 8'hFF; e_ack = 0;
    d  = (m_t / DC) % ND;
    ph = m_t % DC;
    e_fd = m_run && (m_t == FRAME - 1);
    if (m_run && en && ph >= BC) begin
      e_sel = ~(8'h01 << d);
      e_seg = model_seg(d, dp);
    end
    bnd = !m_run || (m_t == FRAME - 1);
    if (bnd) begin
      if (dv) begin m_disp = hd; e_ack = 1; m_pv = 0; end
      else if (m_pv) begin m_disp = m_pend; e_ack = 1; m_pv = 0; end
    end else if (dv) begin
      m_pend = hd; m_pv = 1;
    end
    if (!en) begin m_run = 0; m_t = 0; end
    else if (!m_run) begin m_run = 1; m_t = 0; end
    else m_t = (m_t + 1) % FRAME;
    exp_q.push_back({e_seg, e_sel, e_ack, e_fd});
    @(posedge clk); #1;
    got = {bus.seg, bus.sel, bus.data_ack, bus.frame_done};
    exp = exp_q.pop_front();
    check("outputs{seg,sel,ack,fd}", 32'(got), 32'(exp));
    last_fd  = bus.frame_done;
    last_ack = bus.data_ack;
    if (bus.frame_done) fd_seen++;
    if (bus.data_ack) ack_seen++;
    for (int i = 0; i < ND; i++) if (!bus.sel[i]) obs_seg[i] = bus.seg;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 32'h0, cur_dp);
  endtask

  task automatic run_to_t(input int target);
    int k;
    k = 0;
    while (!(m_run && m_t == target) && k < 200) begin
      step(1, 0, 32'h0, cur_dp);
      k++;
    end
    if (k >= 200) check("run_to_t timeout", 0, 1);
  endtask

  task automatic run_until_fd(input int max);
    int k;
    k = 0;
    last_fd = 0;
    while (!last_fd && k < max) begin
      step(1, 0, 32'h0, cur_dp);
      k++;
    end
    if (!last_fd) check("frame_done timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " seg"}, 32'(bus.seg), 32'hFF);
    check({tag, " sel"}, 32'(bus.sel), 32'hFF);
    check({tag, " data_ack"}, 32'(bus.data_ack), 32'h0);
    check({tag, " frame_done"}, 32'(bus.frame_done), 32'h0);
    check({tag, " state"}, 32'(bus.state), 32'(IDLE));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rnd;
    bus.enable = 0; bus.data_valid = 0; bus.hex_data = '0; bus.dp_mask = '0;
    cur_dp = 8'h00;
    model_reset();
    fd_seen = 0; ack_seen = 0;
    for (int i = 0; i < ND; i++) obs_seg[i] = 8'h00;

    // reset state
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1;

    // 1: free-running scan of value 0
    run(170);
    check("t1 frame_done count", 32'(fd_seen), 2);
    check("t1 ack count", 32'(ack_seen), 0);
    check("t1 digit0 seg", 32'(obs_seg[0]), 32'hC0);
    check("t1 digit1 seg", 32'(obs_seg[1]), 32'hFF);
    check("t1 digit7 seg", 32'(obs_seg[7]), 32'hFF);

    // 2: strobe during digit 0 blank, held until frame boundary
    run_to_t(1);
    ack_seen = 0;
    step(1, 1, 32'h0000_00FF, cur_dp);
    run_until_fd(100);
    check("t2 digit1 old value", 32'(obs_seg[1]), 32'hFF);
    check("t2 ack at frame_done", 32'(last_ack), 1);
    check("t2 ack count", 32'(ack_seen), 1);
    run(FRAME);
    check("t2 digit0 seg", 32'(obs_seg[0]), 32'h8E);
    check("t2 digit1 seg", 32'(obs_seg[1]), 32'h8E);
    check("t2 digit2 seg", 32'(obs_seg[2]), 32'hFF);

    // 3: latest strobe wins; strobe on boundary goes straight through
    ack_seen = 0;
    step(1, 1, 32'h12, cur_dp);
    run(5);
    step(1, 1, 32'h34, cur_dp);
    run_until_fd(100);
    check("t3 single ack", 32'(ack_seen), 1);
    run(FRAME);
    check("t3 digit0 seg", 32'(obs_seg[0]), 32'h99);
    check("t3 digit1 seg", 32'(obs_seg[1]), 32'hB0);
    run_to_t(FRAME - 1);
    step(1, 1, 32'h56, cur_dp);
    check("t3 boundary ack", 32'(last_ack), 1);
    check("t3 boundary frame_done", 32'(last_fd), 1);
    run(FRAME);
    check("t3b digit0 seg", 32'(obs_seg[0]), 32'h82);
    check("t3b digit1 seg", 32'(obs_seg[1]), 32'h92);

    // 4: disable mid digit 3 drive, strobe while idle, restart
    run_to_t(35);
    step(0, 0, 32'h0, cur_dp);
    check("t4 sel dark", 32'(bus.sel), 32'hFF);
    check("t4 seg dark", 32'(bus.seg), 32'hFF);
    check("t4 state idle", 32'(bus.state), 32'(IDLE));
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, cur_dp);
    rnd = $urandom;
    step(0, 1, rnd, cur_dp);
    check("t4 idle ack", 32'(last_ack), 1);
    step(1, 0, 32'h0, cur_dp);
    for (int i = 0; i < 3; i++) step(1, 0, 32'h0, cur_dp);
    check("t4 restart digit0 sel", 32'(bus.sel), 32'hFE);

    // 5: decimal point on digit 0
    cur_dp = 8'h01;
    run_to_t(10);
    step(1, 1, 32'h0000_0100, cur_dp);
    run_until_fd(100);
    run(FRAME);
    check("t5 digit0 seg", 32'(obs_seg[0]), 32'h40);
    check("t5 digit1 seg", 32'(obs_seg[1]), 32'hC0);
    check("t5 digit2 seg", 32'(obs_seg[2]), 32'hF9);
    check("t5 digit3 seg", 32'(obs_seg[3]), 32'hFF);

    // random traffic: strobes, leading zeros, dp changes, short disables
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) cur_dp = 8'($urandom_range(0, 255));
      rnd = $urandom >> (4 * $urandom_range(0, 7));
      step($urandom_range(0, 29) != 0, $urandom_range(0, 11) == 0, rnd, cur_dp);
    end

    // 6: async reset mid drive with pending data
    cur_dp = 8'h00;
    run_to_t(25);
    step(1, 1, 32'hABCD_1234, cur_dp);
    run(2);
    #2;
    rst_n = 0;
    bus.enable = 0; bus.data_valid = 0;
    #1;
    check_reset_outputs("async reset");
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    ack_seen = 0;
    run(100);
    check("t6 no ack after reset", 32'(ack_seen), 0);
    check("t6 digit0 seg", 32'(obs_seg[0]), 32'hC0);
    check("t6 digit1 seg", 32'(obs_seg[1]), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
